// File: rtl/u111_pkg.sv
// Shared types and defaults for the U111 local-bus arbiter.
package u111_pkg;

  localparam int unsigned TurnClksDefault  = 2;
  localparam int unsigned MinCpuTenDefault = 16;

  // State codes are visible on ST, so the encoding is fixed.
  typedef enum logic [2:0] {
    ARB_CPU_PARK    = 3'd0,
    ARB_CPU_DRAIN   = 3'd1,
    ARB_TURN_TO_DMA = 3'd2,
    ARB_DMA_OWN     = 3'd3,
    ARB_TURN_TO_CPU = 3'd4,
    ARB_CPU_TENURE  = 3'd5
  } arb_state_e;

  typedef struct packed {
    logic cpubg_n;
    logic dma_n;
    logic lben_n;
    logic cycle_en;
  } arb_out_t;

  localparam arb_out_t ArbOutPark = '{cpubg_n: 1'b0, dma_n: 1'b1, lben_n: 1'b0, cycle_en: 1'b1};

  // Output levels owned by each state.
  function automatic arb_out_t arb_decode(arb_state_e st);
    arb_out_t o;
    o = ArbOutPark;
    case (st)
      ARB_CPU_DRAIN: begin
        // Buffers stay on so the CPU's last cycle can complete.
        o.cpubg_n = 1'b1;
      end
      ARB_TURN_TO_DMA, ARB_TURN_TO_CPU: begin
        o.cpubg_n  = 1'b1;
        o.lben_n   = 1'b1;
        o.cycle_en = 1'b0;
      end
      ARB_DMA_OWN: begin
        o.cpubg_n  = 1'b1;
        o.dma_n    = 1'b0;
        o.cycle_en = 1'b0;
      end
      default: o = ArbOutPark;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/u111_sync2.sv
// Two-flop synchronizer for a single asynchronous active-low level; resets to 1 (idle).
module u111_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability filter: two back-to-back flops, idle-high after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/u111_bus_arbiter.sv
// 68040 local-bus arbiter: CPU parked by default, hands the bus to the Amiga DMA master on
// request with buffer-off turnaround gaps, and guarantees the CPU a minimum tenure afterwards.
module u111_bus_arbiter
  import u111_pkg::*;
#(
  parameter int unsigned TURN_CLKS   = TurnClksDefault,
  parameter int unsigned MIN_CPU_TEN = MinCpuTenDefault
) (
  input  logic       CLK40,
  input  logic       RESETn,
  input  logic       BRn,
  input  logic       BBn,
  input  logic       TS_CPUn,
  input  logic       LOCKn,
  input  logic       DMA_REQn,
  output logic       CPUBGn,
  output logic       DMAn,
  output logic       LBENn,
  output logic       CYCLE_EN,
  output logic [2:0] ST
);

  localparam logic [2:0] TurnLast = 3'(TURN_CLKS - 1);
  localparam logic [7:0] TenLoad  = 8'(MIN_CPU_TEN);
  localparam bit         TenUsed  = (MIN_CPU_TEN != 0);

  arb_state_e state_q, state_d;
  logic [2:0] turn_cnt_q, turn_cnt_d;
  logic [7:0] ten_cnt_q, ten_cnt_d;
  arb_out_t   out_q;
  logic       dma_req_n_sync;
  logic       req;

  u111_sync2 u_req_sync (
    .clk_i  (CLK40),
    .rst_ni (RESETn),
    .d_i    (DMA_REQn),
    .q_o    (dma_req_n_sync)
  );

  assign req = ~dma_req_n_sync;

  // Next-state and counter logic for the ownership sequence.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    ten_cnt_d  = ten_cnt_q;
    case (state_q)
      ARB_CPU_PARK: begin
        if (req && LOCKn && (ten_cnt_q == 8'd0)) begin
          state_d = ARB_CPU_DRAIN;
        end
      end
      ARB_CPU_DRAIN: begin
        // Lock or a withdrawn request hands the bus straight back to the CPU.
        if (!LOCKn || !req) begin
          state_d = ARB_CPU_PARK;
        end else if (BBn && TS_CPUn) begin
          state_d    = ARB_TURN_TO_DMA;
          turn_cnt_d = 3'd0;
        end
      end
      ARB_TURN_TO_DMA: begin
        // A request drop beats the turn counter expiring in the same clock.
        if (!req) begin
          state_d    = ARB_TURN_TO_CPU;
          turn_cnt_d = 3'd0;
        end else if (turn_cnt_q >= TurnLast) begin
          state_d = ARB_DMA_OWN;
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end
      ARB_DMA_OWN: begin
        if (!req) begin
          state_d    = ARB_TURN_TO_CPU;
          turn_cnt_d = 3'd0;
        end
      end
      ARB_TURN_TO_CPU: begin
        if (turn_cnt_q >= TurnLast) begin
          if (!BRn && TenUsed) begin
            state_d   = ARB_CPU_TENURE;
            ten_cnt_d = TenLoad;
          end else begin
            state_d = ARB_CPU_PARK;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end
      ARB_CPU_TENURE: begin
        // Tenure ends on the clock the count reaches zero, giving MIN_CPU_TEN granted clocks.
        ten_cnt_d = (ten_cnt_q != 8'd0) ? ten_cnt_q - 8'd1 : 8'd0;
        if (ten_cnt_d == 8'd0) begin
          state_d = (req && LOCKn) ? ARB_CPU_DRAIN : ARB_CPU_PARK;
        end
      end
      default: begin
        state_d    = ARB_CPU_PARK;
        turn_cnt_d = 3'd0;
        ten_cnt_d  = 8'd0;
      end
    endcase
  end

  // State and counter registers; reset parks the bus on the CPU.
  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= ARB_CPU_PARK;
      turn_cnt_q <= 3'd0;
      ten_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      ten_cnt_q  <= ten_cnt_d;
    end
  end

  // Outputs registered from the next state so each pin comes straight off a flop.
  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      out_q <= ArbOutPark;
    end else begin
      out_q <= arb_decode(state_d);
    end
  end

  assign CPUBGn   = out_q.cpubg_n;
  assign DMAn     = out_q.dma_n;
  assign LBENn    = out_q.lben_n;
  assign CYCLE_EN = out_q.cycle_en;
  assign ST       = state_q;

endmodule

// File: tb/tb_u111_bus_arbiter.sv
// Self-checking bench for u111_bus_arbiter: directed scenarios plus randomized traffic
// compared against a phase/countdown model of the ownership rules.
module tb_u111_bus_arbiter;
  import u111_pkg::*;

  localparam int TURN = 2;
  localparam int TEN  = 16;

  localparam int P_PARK = 0;
  localparam int P_DRAIN = 1;
  localparam int P_TDMA = 2;
  localparam int P_OWN = 3;
  localparam int P_TCPU = 4;
  localparam int P_TEN = 5;

  logic       CLK40 = 1'b0;
  logic       RESETn, BRn, BBn, TS_CPUn, LOCKn, DMA_REQn;
  logic       CPUBGn, DMAn, LBENn, CYCLE_EN;
  logic [2:0] ST;
  logic [6:0] obs;

  int errors = 0;
  int checks = 0;

  always #12 CLK40 = ~CLK40;

  u111_bus_arbiter #(
    .TURN_CLKS   (TURN),
    .MIN_CPU_TEN (TEN)
  ) dut (
    .CLK40    (CLK40),
    .RESETn   (RESETn),
    .BRn      (BRn),
    .BBn      (BBn),
    .TS_CPUn  (TS_CPUn),
    .LOCKn    (LOCKn),
    .DMA_REQn (DMA_REQn),
    .CPUBGn   (CPUBGn),
    .DMAn     (DMAn),
    .LBENn    (LBENn),
    .CYCLE_EN (CYCLE_EN),
    .ST       (ST)
  );

  assign obs = {CPUBGn, DMAn, LBENn, CYCLE_EN, ST};

  // Reference model: who owns the bus, plus countdowns of clocks left in each timed phase.
  int   m_phase, m_left, m_ten;
  logic m_s1, m_s2, m_req;
  assign m_req = !m_s2;

  always @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      m_phase <= P_PARK;
      m_left  <= 0;
      m_ten   <= 0;
      m_s1    <= 1'b1;
      m_s2    <= 1'b1;
    end else begin
      m_s1 <= DMA_REQn;
      m_s2 <= m_s1;
      case (m_phase)
        P_PARK: if (m_req && LOCKn) m_phase <= P_DRAIN;
        P_DRAIN: begin
          if (!LOCKn || !m_req) m_phase <= P_PARK;
          else if (BBn && TS_CPUn) begin
            m_phase <= P_TDMA;
            m_left  <= TURN;
          end
        end
        P_TDMA: begin
          if (!m_req) begin
            m_phase <= P_TCPU;
            m_left  <= TURN;
          end else if (m_left == 1) m_phase <= P_OWN;
          else m_left <= m_left - 1;
        end
        P_OWN: begin
          if (!m_req) begin
            m_phase <= P_TCPU;
            m_left  <= TURN;
          end
        end
        P_TCPU: begin
          if (m_left == 1) begin
            if (!BRn && TEN > 0) begin
              m_phase <= P_TEN;
              m_ten   <= TEN;
            end else m_phase <= P_PARK;
          end else m_left <= m_left - 1;
        end
        P_TEN: begin
          if (m_ten == 1) m_phase <= (m_req && LOCKn) ? P_DRAIN : P_PARK;
          else m_ten <= m_ten - 1;
        end
        default: m_phase <= P_PARK;
      endcase
    end
  end

  // Expected {CPUBGn, DMAn, LBENn, CYCLE_EN, ST} for a model phase.
  function automatic logic [6:0] exp_of(int ph);
    case (ph)
      P_DRAIN: return {4'b1101, 3'(ARB_CPU_DRAIN)};
      P_TDMA:  return {4'b1110, 3'(ARB_TURN_TO_DMA)};
      P_OWN:   return {4'b1000, 3'(ARB_DMA_OWN)};
      P_TCPU:  return {4'b1110, 3'(ARB_TURN_TO_CPU)};
      P_TEN:   return {4'b0101, 3'(ARB_CPU_TENURE)};
      default: return {4'b0101, 3'(ARB_CPU_PARK)};
    endcase
  endfunction

  task automatic test_reset();
    RESETn = 1'b0; BRn = 1'b1; BBn = 1'b1; TS_CPUn = 1'b1; LOCKn = 1'b1; DMA_REQn = 1'b1;
    repeat (3) @(negedge CLK40);
    checks++; if (CPUBGn !== 1'b0) begin errors++; $display("FAIL reset_cpubg got=%b want=0", CPUBGn); end
    checks++; if (DMAn !== 1'b1) begin errors++; $display("FAIL reset_dma got=%b want=1", DMAn); end
    checks++; if (LBENn !== 1'b0) begin errors++; $display("FAIL reset_lben got=%b want=0", LBENn); end
    checks++; if (CYCLE_EN !== 1'b1) begin errors++; $display("FAIL reset_cyc got=%b want=1", CYCLE_EN); end
    checks++; if (ST !== 3'd0) begin errors++; $display("FAIL reset_st got=%0d want=0", ST); end
    RESETn = 1'b1;
    repeat (3) begin
      @(negedge CLK40);
      checks++;
      if (obs !== exp_of(m_phase)) begin
        errors++; $display("FAIL reset_idle got=%b want=%b", obs, exp_of(m_phase));
      end
    end
  endtask

  task automatic test_idle_latency();
    logic e_bg, e_dma, e_lb;
    @(negedge CLK40);
    DMA_REQn = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge CLK40);
      e_bg = (j >= 3); e_lb = (j == 4 || j == 5); e_dma = (j < 6);
      checks++; if (CPUBGn !== e_bg) begin
        errors++; $display("FAIL idle_cpubg t0+%0d got=%b want=%b", j, CPUBGn, e_bg); end
      checks++; if (LBENn !== e_lb) begin
        errors++; $display("FAIL idle_lben t0+%0d got=%b want=%b", j, LBENn, e_lb); end
      checks++; if (DMAn !== e_dma) begin
        errors++; $display("FAIL idle_dma t0+%0d got=%b want=%b", j, DMAn, e_dma); end
    end
    DMA_REQn = 1'b1;
    repeat (10) begin
      @(negedge CLK40);
      checks++;
      if (obs !== exp_of(m_phase)) begin
        errors++; $display("FAIL idle_release got=%b want=%b", obs, exp_of(m_phase));
      end
    end
  endtask

  task automatic test_busy_cpu();
    @(negedge CLK40);
    BBn = 1'b0; DMA_REQn = 1'b0;
    repeat (5) begin
      @(negedge CLK40);
      checks++; if (DMAn !== 1'b1) begin errors++; $display("FAIL busy_dma_early got=%b want=1", DMAn); end
    end
    checks++; if (ST !== 3'(ARB_CPU_DRAIN)) begin
      errors++; $display("FAIL busy_drain got=%0d want=%0d", ST, 3'(ARB_CPU_DRAIN)); end
    BBn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK40);
      checks++; if (DMAn !== (k < 3)) begin
        errors++; $display("FAIL busy_dma_after k=%0d got=%b want=%b", k, DMAn, (k < 3)); end
    end
    DMA_REQn = 1'b1;
    repeat (8) begin
      @(negedge CLK40);
      checks++;
      if (obs !== exp_of(m_phase)) begin
        errors++; $display("FAIL busy_release got=%b want=%b", obs, exp_of(m_phase));
      end
    end
  endtask

  task automatic test_lock();
    @(negedge CLK40);
    LOCKn = 1'b0; DMA_REQn = 1'b0;
    repeat (10) begin
      @(negedge CLK40);
      checks++; if (CPUBGn !== 1'b0) begin errors++; $display("FAIL lock_hold got=%b want=0", CPUBGn); end
    end
    LOCKn = 1'b1;
    @(negedge CLK40);
    checks++; if (CPUBGn !== 1'b1) begin errors++; $display("FAIL lock_release got=%b want=1", CPUBGn); end
    repeat (6) begin
      @(negedge CLK40);
      checks++;
      if (obs !== exp_of(m_phase)) begin
        errors++; $display("FAIL lock_handoff got=%b want=%b", obs, exp_of(m_phase));
      end
    end
    checks++; if (DMAn !== 1'b0) begin errors++; $display("FAIL lock_dma got=%b want=0", DMAn); end
    DMA_REQn = 1'b1;
    repeat (8) @(negedge CLK40);
  endtask

  task automatic test_abort();
    @(negedge CLK40);
    BBn = 1'b0; DMA_REQn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK40);
      checks++; if (DMAn !== 1'b1) begin errors++; $display("FAIL abort_dma k=%0d got=%b want=1", k, DMAn); end
      if (k == 3) begin
        checks++; if (CPUBGn !== 1'b1) begin
          errors++; $display("FAIL abort_drain got=%b want=1", CPUBGn); end
        DMA_REQn = 1'b1;
      end
    end
    checks++; if (CPUBGn !== 1'b0) begin errors++; $display("FAIL abort_regrant got=%b want=0", CPUBGn); end
    BBn = 1'b1;
  endtask

  task automatic test_tenure();
    int n;
    @(negedge CLK40);
    BRn = 1'b0; DMA_REQn = 1'b0;
    n = 0;
    while (DMAn !== 1'b0 && n < 20) begin @(negedge CLK40); n++; end
    checks++; if (DMAn !== 1'b0) begin errors++; $display("FAIL ten_own got=%b want=0", DMAn); end
    DMA_REQn = 1'b1;
    @(negedge CLK40);
    DMA_REQn = 1'b0;
    n = 0;
    while (CPUBGn !== 1'b0 && n < 20) begin @(negedge CLK40); n++; end
    n = 0;
    while (CPUBGn === 1'b0 && n < 40) begin @(negedge CLK40); n++; end
    checks++; if (n != TEN) begin errors++; $display("FAIL ten_len got=%0d want=%0d", n, TEN); end
    DMA_REQn = 1'b1; BRn = 1'b1;
    repeat (12) begin
      @(negedge CLK40);
      checks++;
      if (obs !== exp_of(m_phase)) begin
        errors++; $display("FAIL ten_release got=%b want=%b", obs, exp_of(m_phase));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge CLK40);
    DMA_REQn = 1'b0;
    n = 0;
    while (DMAn !== 1'b0 && n < 20) begin @(negedge CLK40); n++; end
    checks++; if (DMAn !== 1'b0) begin errors++; $display("FAIL rmid_own got=%b want=0", DMAn); end
    #3 RESETn = 1'b0;
    #1;
    checks++; if ({CPUBGn, DMAn, LBENn, CYCLE_EN, ST} !== 7'b0101000) begin
      errors++; $display("FAIL rmid_async got=%b want=0101000", obs); end
    DMA_REQn = 1'b1;
    @(negedge CLK40);
    RESETn = 1'b1;
    repeat (4) begin
      @(negedge CLK40);
      checks++;
      if (obs !== exp_of(m_phase)) begin
        errors++; $display("FAIL rmid_after got=%b want=%b", obs, exp_of(m_phase));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK40);
      checks++;
      if (obs !== exp_of(m_phase)) begin
        errors++; $display("FAIL rand_model c=%0d got=%b want=%b", c, obs, exp_of(m_phase));
      end
      checks++;
      if (CPUBGn === 1'b0 && DMAn === 1'b0) begin
        errors++; $display("FAIL rand_both_owners c=%0d got=00 want=not-both-low", c);
      end
      if ($urandom_range(0, 7) == 0) DMA_REQn = ~DMA_REQn;
      BBn     = ($urandom_range(0, 3) != 0);
      TS_CPUn = ($urandom_range(0, 3) != 0);
      LOCKn   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0) BRn = ~BRn;
    end
  endtask

  initial begin
    test_reset();
    test_idle_latency();
    test_busy_cpu();
    test_lock();
    test_abort();
    test_tenure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
